branch_resolve_unit: RTL and testbench

- Writer side of the branch target buffer. Takes resolved branches from execute through a valid/ready handshake and compares each one against its fetch-time prediction.
- On a mispredict it issues a one-cycle fetch redirect. Taken branches are queued and drained one per cycle onto the BTB update port (update_valid/update_pc/update_target).
- Also keeps saturating branch and mispredict performance counters.

---
 rtl/branch_resolve_unit.sv | 252 +++++++++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Writer side of the branch target buffer. Resolved branches arrive from
// execute, are registered into a single evaluation stage (S1) and compared
// against the prediction made at fetch time. A mispredict produces a one-cycle
// fetch redirect. Taken branches are pushed into a small circular queue that
// drains one entry per cycle onto the BTB update port. Two saturating
// performance counters track evaluated branches and mispredicts.
//
// Handshake: a record transfers on a rising clk edge where res_valid and
// res_ready are both high. res_valid may be raised at any time; the record
// fields must be held stable while res_valid is high and res_ready is low.
// res_ready depends only on flush_in and internal state, never on res_valid.
// The BTB update port has no ready: update_valid is a strobe the BTB must
// accept; upd_hold is the only way to stall it.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   res_valid/res_ready  resolved-branch handshake
//   res_pc               branch PC
//   res_taken            actual direction
//   res_target           actual target (meaningful when res_taken=1)
//   res_pred_taken       direction predicted at fetch
//   res_pred_target      target predicted at fetch
//   flush_in             pipeline flush; kills S1 and blocks accepts
//   redirect_valid/_pc   one-cycle fetch redirect and correct next PC
//   upd_hold             freeze the update queue head this cycle
//   update_valid/_pc/_target  BTB write strobe, index PC and target
//   q_count              update queue occupancy
//   branch_cnt           branches evaluated (saturating)
//   mispred_cnt          mispredicts detected (saturating)
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int PC_W       = 8,
    parameter int UPDQ_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          res_valid,
    output logic                          res_ready,
    input  logic [PC_W-1:0]               res_pc,
    input  logic                          res_taken,
    input  logic [PC_W-1:0]               res_target,
    input  logic                          res_pred_taken,
    input  logic [PC_W-1:0]               res_pred_target,

    input  logic                          flush_in,

    output logic                          redirect_valid,
    output logic [PC_W-1:0]               redirect_pc,

    input  logic                          upd_hold,
    output logic                          update_valid,
    output logic [PC_W-1:0]               update_pc,
    output logic [PC_W-1:0]               update_target,

    output logic [$clog2(UPDQ_DEPTH):0]   q_count,
    output logic [CNT_W-1:0]              branch_cnt,
    output logic [CNT_W-1:0]              mispred_cnt
);

    localparam int AW  = $clog2(UPDQ_DEPTH);
    localparam int QCW = AW + 1;

    // ------------------------------------------------------------------
    // S1 evaluation stage
    // ------------------------------------------------------------------
    logic            s1_valid_q;
    logic [PC_W-1:0] s1_pc_q;
    logic            s1_taken_q;
    logic [PC_W-1:0] s1_target_q;
    logic            s1_pred_taken_q;
    logic [PC_W-1:0] s1_pred_target_q;

    logic            accept;
    logic            eval;
    logic            mispred;
    logic [PC_W-1:0] correct_pc;

    // ------------------------------------------------------------------
    // Update queue
    // ------------------------------------------------------------------
    logic [PC_W-1:0] qpc_q  [UPDQ_DEPTH];
    logic [PC_W-1:0] qtgt_q [UPDQ_DEPTH];
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [QCW-1:0]  count_q, count_d;
    logic [QCW-1:0]  occupancy;
    logic            push;
    logic            pop;

    // Dedupe register: last entry actually enqueued
    logic            last_valid_q;
    logic [PC_W-1:0] last_pc_q;
    logic [PC_W-1:0] last_target_q;
    logic            dup;

    // Redirect and counters
    logic            redirect_valid_q;
    logic [PC_W-1:0] redirect_pc_q;
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_q;

    // ------------------------------------------------------------------
    // Accept side. The record sitting in S1 is counted against queue
    // space because it may still be pushed at the next edge; this is what
    // makes overflow impossible without any extra check on push.
    // ------------------------------------------------------------------
    assign occupancy = count_q + QCW'(s1_valid_q);
    assign res_ready = !flush_in && (occupancy < QCW'(UPDQ_DEPTH));
    assign accept    = res_valid && res_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q       <= 1'b0;
            s1_pc_q          <= '0;
            s1_taken_q       <= 1'b0;
            s1_target_q      <= '0;
            s1_pred_taken_q  <= 1'b0;
            s1_pred_target_q <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_pc_q          <= res_pc;
                s1_taken_q       <= res_taken;
                s1_target_q      <= res_target;
                s1_pred_taken_q  <= res_pred_taken;
                s1_pred_target_q <= res_pred_target;
            end
        end
    end

    // ------------------------------------------------------------------
    // Evaluation. Target only matters when both actual and predicted
    // directions are taken. Fall-through wraps naturally at PC_W bits.
    // ------------------------------------------------------------------
    assign eval       = s1_valid_q && !flush_in;
    assign mispred    = (s1_taken_q != s1_pred_taken_q) ||
                        (s1_taken_q && s1_pred_taken_q &&
                         (s1_target_q != s1_pred_target_q));
    assign correct_pc = s1_taken_q ? s1_target_q : (s1_pc_q + 1'b1);

    assign dup  = last_valid_q && (last_pc_q == s1_pc_q) &&
                  (last_target_q == s1_target_q);
    assign push = eval && s1_taken_q && !dup;
    assign pop  = update_valid;

    // ------------------------------------------------------------------
    // Redirect pulse: redirect_pc keeps its last value when not redirecting
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            redirect_valid_q <= eval && mispred;
            if (eval && mispred) begin
                redirect_pc_q <= correct_pc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (eval && (branch_cnt_q != '1)) begin
                branch_cnt_q <= branch_cnt_q + 1'b1;
            end
            if (eval && mispred && (mispred_cnt_q != '1)) begin
                mispred_cnt_q <= mispred_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Dedupe register: only an actual enqueue updates it
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_valid_q  <= 1'b0;
            last_pc_q     <= '0;
            last_target_q <= '0;
        end else if (push) begin
            last_valid_q  <= 1'b1;
            last_pc_q     <= s1_pc_q;
            last_target_q <= s1_target_q;
        end
    end

    // ------------------------------------------------------------------
    // Queue pointers. Depth is a power of two so pointer wrap is implicit.
    // ------------------------------------------------------------------
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset: the read port is gated by count, so stale data
    // never reaches the outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            qpc_q[tail_q]  <= s1_pc_q;
            qtgt_q[tail_q] <= s1_target_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign update_valid   = (count_q != '0) && !upd_hold;
    assign update_pc      = update_valid ? qpc_q[head_q]  : '0;
    assign update_target  = update_valid ? qtgt_q[head_q] : '0;

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign q_count        = count_q;
    assign branch_cnt     = branch_cnt_q;
    assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit. Inputs change 1ns after the rising
// edge and outputs are sampled 2ns after it.
module tb_branch_resolve_unit;

  localparam int PC_W  = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             res_valid = 1'b0;
  logic             res_ready;
  logic [PC_W-1:0]  res_pc = '0;
  logic             res_taken = 1'b0;
  logic [PC_W-1:0]  res_target = '0;
  logic             res_pred_taken = 1'b0;
  logic [PC_W-1:0]  res_pred_target = '0;
  logic             flush_in = 1'b0;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic             upd_hold = 1'b0;
  logic             update_valid;
  logic [PC_W-1:0]  update_pc;
  logic [PC_W-1:0]  update_target;
  logic [$clog2(DEPTH):0] q_count;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  int num_checks = 0;
  int num_errors = 0;

  // scoreboard of expected BTB updates, {pc, target}
  logic [2*PC_W-1:0] exp_q[$];

  branch_resolve_unit #(
    .PC_W(PC_W), .UPDQ_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_pc(res_pc), .res_taken(res_taken), .res_target(res_target),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
    .flush_in(flush_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_hold(upd_hold),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_target(update_target),
    .q_count(q_count), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [PC_W-1:0] pc, input logic tk, input logic [PC_W-1:0] tgt,
                       input logic ptk, input logic [PC_W-1:0] ptgt);
    res_valid       = 1'b1;
    res_pc          = pc;
    res_taken       = tk;
    res_target      = tgt;
    res_pred_taken  = ptk;
    res_pred_target = ptgt;
  endtask

  // Called 1ns after an edge; returns 2ns after the accepting edge k.
  task automatic accept_one(input string tag, input logic [PC_W-1:0] pc, input logic tk,
                            input logic [PC_W-1:0] tgt, input logic ptk,
                            input logic [PC_W-1:0] ptgt);
    drive(pc, tk, tgt, ptk, ptgt);
    #1;
    check({tag, "_ready"}, 32'(res_ready), 32'd1);
    tick();
    res_valid = 1'b0;
    #1;
  endtask

  int sent;
  int drained;
  int upd_seen;
  logic [2*PC_W-1:0] exp_e;

  initial begin
    // ---------------- reset state ----------------
    #2;
    check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst_redirect_pc", 32'(redirect_pc), 32'd0);
    check("rst_update_valid", 32'(update_valid), 32'd0);
    check("rst_update_pc", 32'(update_pc), 32'd0);
    check("rst_q_count", 32'(q_count), 32'd0);
    check("rst_branch_cnt", 32'(branch_cnt), 32'd0);
    check("rst_mispred_cnt", 32'(mispred_cnt), 32'd0);
    check("rst_res_ready", 32'(res_ready), 32'd1);
    #10 rst = 1'b0;
    tick();

    // ---------------- correct prediction ----------------
    accept_one("ok", 8'h10, 1'b1, 8'h40, 1'b1, 8'h40);
    tick(); #1;
    check("ok_redirect", 32'(redirect_valid), 32'd0);
    check("ok_upd_valid", 32'(update_valid), 32'd1);
    check("ok_upd_pc", 32'(update_pc), 32'h10);
    check("ok_upd_tgt", 32'(update_target), 32'h40);
    check("ok_branch_cnt", 32'(branch_cnt), 32'd1);
    check("ok_mispred_cnt", 32'(mispred_cnt), 32'd0);
    tick(); #1;
    check("ok_drained", 32'(q_count), 32'd0);

    // ---------------- direction mispredict with PC wrap ----------------
    tick();
    accept_one("dir", 8'hFF, 1'b0, 8'h00, 1'b1, 8'h12);
    tick(); #1;
    check("dir_redirect", 32'(redirect_valid), 32'd1);
    check("dir_redirect_pc", 32'(redirect_pc), 32'h00);
    check("dir_no_update", 32'(update_valid), 32'd0);
    check("dir_mispred_cnt", 32'(mispred_cnt), 32'd1);
    check("dir_branch_cnt", 32'(branch_cnt), 32'd2);
    tick(); #1;
    check("dir_pulse_end", 32'(redirect_valid), 32'd0);

    // ---------------- target mispredict ----------------
    accept_one("tgt", 8'h20, 1'b1, 8'h80, 1'b1, 8'h60);
    tick(); #1;
    check("tgt_redirect", 32'(redirect_valid), 32'd1);
    check("tgt_redirect_pc", 32'(redirect_pc), 32'h80);
    check("tgt_upd_valid", 32'(update_valid), 32'd1);
    check("tgt_upd_pc", 32'(update_pc), 32'h20);
    check("tgt_upd_tgt", 32'(update_target), 32'h80);
    check("tgt_mispred_cnt", 32'(mispred_cnt), 32'd2);
    tick(); #1;
    check("tgt_pulse_end", 32'(redirect_valid), 32'd0);
    check("tgt_q_empty", 32'(q_count), 32'd0);

    // ---------------- backpressure with upd_hold ----------------
    sent = 0;
    drained = 0;
    upd_hold = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      tick();
      if (cyc == 10) upd_hold = 1'b0;
      if (sent < 6) drive(8'h40 + 8'(sent), 1'b1, 8'h90 + 8'(sent), 1'b1, 8'h90 + 8'(sent));
      else res_valid = 1'b0;
      #1;
      if (cyc == 4) begin
        check("bp_q3_s1_ready", 32'(res_ready), 32'd0);
        check("bp_q3_count", 32'(q_count), 32'd3);
      end
      if (cyc == 8) begin
        check("bp_full_count", 32'(q_count), 32'd4);
        check("bp_full_ready", 32'(res_ready), 32'd0);
        check("bp_full_sent", 32'(sent), 32'd4);
        check("bp_hold_no_upd", 32'(update_valid), 32'd0);
      end
      if (update_valid) begin
        if (exp_q.size() == 0) begin
          check("bp_unexpected_upd", 32'(update_pc), 32'hFFFF);
        end else begin
          exp_e = exp_q.pop_front();
          check("bp_order_pc", 32'(update_pc), 32'(exp_e[2*PC_W-1:PC_W]));
          check("bp_order_tgt", 32'(update_target), 32'(exp_e[PC_W-1:0]));
          drained++;
        end
      end
      if (res_valid && res_ready) begin
        exp_q.push_back({res_pc, res_target});
        sent++;
      end
      if (cyc > 10 && sent == 6 && drained == 6) break;
    end
    res_valid = 1'b0;
    check("bp_drained_all", 32'(drained), 32'd6);
    tick(); #1;
    check("bp_q_empty", 32'(q_count), 32'd0);
    check("bp_branch_cnt", 32'(branch_cnt), 32'd9);

    // ---------------- flush kills S1 ----------------
    accept_one("fl", 8'h50, 1'b1, 8'h70, 1'b0, 8'h00);
    flush_in = 1'b1;
    #1;
    check("fl_ready_low", 32'(res_ready), 32'd0);
    tick();
    flush_in = 1'b0;
    #1;
    check("fl_no_redirect", 32'(redirect_valid), 32'd0);
    check("fl_no_enqueue", 32'(q_count), 32'd0);
    check("fl_branch_cnt", 32'(branch_cnt), 32'd9);
    check("fl_mispred_cnt", 32'(mispred_cnt), 32'd2);

    // ---------------- dedupe ----------------
    upd_seen = 0;
    drive(8'h30, 1'b1, 8'h50, 1'b1, 8'h50);
    for (int cyc = 0; cyc < 8; cyc++) begin
      tick();
      if (cyc >= 1) res_valid = 1'b0;
      #1;
      if (update_valid && update_pc == 8'h30 && update_target == 8'h50) upd_seen++;
    end
    check("dd_single_update", 32'(upd_seen), 32'd1);
    check("dd_branch_cnt", 32'(branch_cnt), 32'd11);

    // ---------------- async reset mid-operation ----------------
    upd_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(8'h60 + 8'(i), 1'b1, 8'hA0 + 8'(i), (i == 2) ? 1'b0 : 1'b1, 8'hA0 + 8'(i));
      tick();
    end
    res_valid = 1'b0;
    #1;
    check("ar_pre_q_count", 32'(q_count), 32'd3);
    check("ar_pre_redirect", 32'(redirect_valid), 32'd1);
    upd_hold = 1'b0;
    rst = 1'b1;
    #1;
    check("ar_redirect", 32'(redirect_valid), 32'd0);
    check("ar_redirect_pc", 32'(redirect_pc), 32'd0);
    check("ar_update_valid", 32'(update_valid), 32'd0);
    check("ar_q_count", 32'(q_count), 32'd0);
    check("ar_branch_cnt", 32'(branch_cnt), 32'd0);
    check("ar_mispred_cnt", 32'(mispred_cnt), 32'd0);
    tick();
    #3 rst = 1'b0;
    upd_seen = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      tick(); #1;
      if (update_valid || redirect_valid) upd_seen++;
    end
    check("ar_no_stale", 32'(upd_seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #20000;
    num_errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
